// File: rtl/booth_pkg.sv
// Shared constants, state type and control-word helpers for the radix-2 Booth sequencer.
package booth_pkg;

    localparam logic [1:0] CTRL_LOAD  = 2'b00;
    localparam logic [1:0] CTRL_RESET = 2'b01;
    localparam logic [1:0] CTRL_SHIFT = 2'b10;
    localparam logic [1:0] CTRL_HOLD  = 2'b11;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ARITH,
        ST_SHIFT,
        ST_DONE
    } booth_state_t;

    typedef struct packed {
        logic [1:0] a_ctrl;
        logic [1:0] q_ctrl;
        logic       m_load;
        logic       qm1_clr;
        logic       busy;
        logic       done;
    } ctrl_out_t;

    typedef struct packed {
        logic [1:0] a_ctrl;
        logic       add_sub;
    } arith_ctrl_t;

    localparam ctrl_out_t OUT_IDLE = '{
        a_ctrl:  CTRL_HOLD,
        q_ctrl:  CTRL_HOLD,
        m_load:  1'b0,
        qm1_clr: 1'b0,
        busy:    1'b0,
        done:    1'b0
    };

    // State-only control word; the ARITH a_ctrl/add_sub are overlaid separately.
    function automatic ctrl_out_t moore_out(input booth_state_t st);
        ctrl_out_t o;
        o = OUT_IDLE;
        case (st)
            ST_INIT: begin
                o.a_ctrl  = CTRL_RESET;
                o.q_ctrl  = CTRL_LOAD;
                o.m_load  = 1'b1;
                o.qm1_clr = 1'b1;
                o.busy    = 1'b1;
            end
            ST_ARITH: o.busy = 1'b1;
            ST_SHIFT: begin
                o.a_ctrl = CTRL_SHIFT;
                o.q_ctrl = CTRL_SHIFT;
                o.busy   = 1'b1;
            end
            ST_DONE: o.done = 1'b1;
            default: ;
        endcase
        return o;
    endfunction

    // Booth bit-pair recoding: 10 subtracts M, 01 adds M, 00/11 leave A alone.
    function automatic arith_ctrl_t booth_decode(input logic q0, input logic q_m1);
        arith_ctrl_t r;
        r.a_ctrl  = CTRL_HOLD;
        r.add_sub = ADD;
        if (q0 && !q_m1) begin
            r.a_ctrl  = CTRL_LOAD;
            r.add_sub = SUB;
        end else if (!q0 && q_m1) begin
            r.a_ctrl  = CTRL_LOAD;
        end
        return r;
    endfunction

endpackage

// File: rtl/booth_iter_cnt.sv
// Loadable down-counter holding the remaining Booth iterations; saturates at zero.
module booth_iter_cnt
    import booth_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] count_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(WIDTH);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequencing FSM for a radix-2 Booth shift-add multiplier datapath.
// Define BOOTH_SKIP_EN to add port q1 and skip ARITH cycles whose bit pair needs no add/sub.
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             q0,
    input  logic             q_m1,
`ifdef BOOTH_SKIP_EN
    input  logic             q1,
`endif
    output logic [1:0]       a_ctrl,
    output logic [1:0]       q_ctrl,
    output logic             m_load,
    output logic             qm1_clr,
    output logic             add_sub,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    booth_state_t state_q, state_d;
    ctrl_out_t    out_q, out_d;
    arith_ctrl_t  arith_c;
    logic         cnt_zero;
    logic         last_iter;

    booth_iter_cnt #(
        .WIDTH(WIDTH)
    ) u_iter_cnt (
        .clk_i  (clock),
        .rst_ni (reset_n),
        .load_i (state_q == ST_INIT),
        .dec_i  (state_q == ST_SHIFT),
        .count_o(iter),
        .zero_o (cnt_zero)
    );

    // Zero is unreachable in SHIFT; treating it as final keeps iter from wrapping.
    assign last_iter = (iter == CNT_W'(1)) || cnt_zero;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
`ifdef BOOTH_SKIP_EN
                state_d = q0 ? ST_ARITH : ST_SHIFT;
`else
                state_d = ST_ARITH;
`endif
            end
            ST_ARITH: state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (last_iter) begin
                    state_d = ST_DONE;
                end else begin
`ifdef BOOTH_SKIP_EN
                    // q1/q0 are the post-shift q0/q_m1 pair.
                    state_d = (q1 == q0) ? ST_SHIFT : ST_ARITH;
`else
                    state_d = ST_ARITH;
`endif
                end
            end
            ST_DONE: state_d = start ? ST_INIT : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        out_d = moore_out(state_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            out_q   <= OUT_IDLE;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // q0/q_m1 only reach the outputs while in ARITH.
    always_comb begin
        arith_c = booth_decode(q0, q_m1);
        a_ctrl  = out_q.a_ctrl;
        add_sub = ADD;
        if (state_q == ST_ARITH) begin
            a_ctrl  = arith_c.a_ctrl;
            add_sub = arith_c.add_sub;
        end
    end

    assign q_ctrl  = out_q.q_ctrl;
    assign m_load  = out_q.m_load;
    assign qm1_clr = out_q.qm1_clr;
    assign busy    = out_q.busy;
    assign done    = out_q.done;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: Booth datapath model, phase-schedule reference model and directed operations.
`timescale 1ns/1ps
module tb_booth_seq_ctrl;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);
`ifdef BOOTH_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    localparam bit PIN = !SKIP;

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_NOP   = 2;
    localparam int P_SUB   = 3;
    localparam int P_ADD   = 4;
    localparam int P_SHIFT = 5;
    localparam int P_DONE  = 6;

    logic clock   = 1'b0;
    logic reset_n = 1'b1;
    logic start   = 1'b0;
    logic q0, q_m1;
`ifdef BOOTH_SKIP_EN
    logic q1;
`endif
    logic [1:0]    a_ctrl, q_ctrl;
    logic          m_load, qm1_clr, add_sub, busy, done;
    logic [CW-1:0] iter;

    logic [W-1:0] mcand_in = '0;
    logic [W-1:0] mult_in  = '0;

    logic [W:0]   a_r;
    logic [W-1:0] q_r, m_r;
    logic         qm1_r;

    int n_vec = 0;
    int n_mis = 0;

    always #5 clock = ~clock;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .start  (start),
        .q0     (q0),
        .q_m1   (q_m1),
`ifdef BOOTH_SKIP_EN
        .q1     (q1),
`endif
        .a_ctrl (a_ctrl),
        .q_ctrl (q_ctrl),
        .m_load (m_load),
        .qm1_clr(qm1_clr),
        .add_sub(add_sub),
        .busy   (busy),
        .done   (done),
        .iter   (iter)
    );

    // Datapath: A carries one guard bit so that M = most-negative value still multiplies correctly.
    assign q0   = m_load ? mult_in[0] : q_r[0];
    assign q_m1 = qm1_r;
`ifdef BOOTH_SKIP_EN
    assign q1   = q_r[1];
`endif

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_r   <= '0;
            q_r   <= '0;
            m_r   <= '0;
            qm1_r <= 1'b0;
        end else begin
            if (m_load) m_r <= mcand_in;
            case (a_ctrl)
                2'b00:   a_r <= add_sub ? a_r - {m_r[W-1], m_r} : a_r + {m_r[W-1], m_r};
                2'b01:   a_r <= '0;
                2'b10:   a_r <= {a_r[W], a_r[W:1]};
                default: ;
            endcase
            case (q_ctrl)
                2'b00:   q_r <= mult_in;
                2'b10:   q_r <= {a_r[0], q_r[W-1:1]};
                default: ;
            endcase
            if (qm1_clr)             qm1_r <= 1'b0;
            else if (q_ctrl == 2'b10) qm1_r <= q_r[0];
        end
    end

    // Phase k of an operation: INIT, then per bit i an optional ARITH and a SHIFT, then DONE.
    function automatic int phase_at(input logic [W-1:0] mu, input int k, output int it);
        logic prev, cur;
        int   pos;
        it = 0;
        if (k == 0) return P_INIT;
        pos  = 1;
        prev = 1'b0;
        for (int i = 0; i < W; i++) begin
            cur = mu[i];
            if (!SKIP || (cur != prev)) begin
                if (k == pos) begin
                    it = W - i;
                    return (cur == prev) ? P_NOP : (cur ? P_SUB : P_ADD);
                end
                pos++;
            end
            if (k == pos) begin
                it = W - i;
                return P_SHIFT;
            end
            pos++;
            prev = cur;
        end
        return P_DONE;
    endfunction

    // {a_ctrl, q_ctrl, m_load, qm1_clr, add_sub, busy, done}
    function automatic logic [8:0] exp_vec(input int ph);
        case (ph)
            P_INIT:  return {2'b01, 2'b00, 3'b110, 2'b10};
            P_NOP:   return {2'b11, 2'b11, 3'b000, 2'b10};
            P_SUB:   return {2'b00, 2'b11, 3'b001, 2'b10};
            P_ADD:   return {2'b00, 2'b11, 3'b000, 2'b10};
            P_SHIFT: return {2'b10, 2'b10, 3'b000, 2'b10};
            P_DONE:  return {2'b11, 2'b11, 3'b000, 2'b01};
            default: return {2'b11, 2'b11, 3'b000, 2'b00};
        endcase
    endfunction

    function automatic logic [2*W-1:0] exp_product(input logic [W-1:0] a, input logic [W-1:0] b);
        int sa, sb, p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return (2*W)'(p);
    endfunction

    function automatic logic [31:0] outs();
        return 32'({a_ctrl, q_ctrl, m_load, qm1_clr, add_sub, busy, done, iter});
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: an operation is just a position in its phase schedule.
    logic         m_active;
    int           m_k;
    logic [W-1:0] m_mult;
    int           cur_ph, cur_it;

    always_comb begin
        cur_ph = P_IDLE;
        cur_it = 0;
        if (m_active) cur_ph = phase_at(m_mult, m_k, cur_it);
    end

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_mult   <= '0;
        end else if (!m_active || (cur_ph == P_DONE)) begin
            m_active <= start;
            m_k      <= 0;
            if (start) m_mult <= mult_in;
        end else begin
            m_k <= m_k + 1;
        end
    end

    always @(negedge clock) begin
        if (reset_n) check("cycle", outs(), 32'({exp_vec(cur_ph), CW'(cur_it)}));
    end

    task automatic run_op(input logic [W-1:0] mc, input logic [W-1:0] mu, input bit pin,
                          input logic [2*W-1:0] l_prod, input int l_lat,
                          input logic [11:0] l_arith, input logic [15:0] l_iter);
        int           lat, busy_n;
        bit           seen;
        logic [11:0]  alog;
        logic [15:0]  ilog;
        logic [2*W-1:0] prod;
        mcand_in = mc;
        mult_in  = mu;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat = 1; busy_n = 0; seen = 1'b0; alog = '0; ilog = '0; prod = '0;
        for (int c = 0; c < 64 && !seen; c++) begin
            @(negedge clock);
            if (busy) busy_n++;
            if (busy && (q_ctrl == 2'b11)) alog = {alog[8:0], a_ctrl, add_sub};
            if (q_ctrl == 2'b10) ilog = {ilog[11:0], 4'(iter)};
            if (done) begin
                seen = 1'b1;
                prod = {a_r[W-1:0], q_r};
            end else begin
                @(posedge clock);
                lat++;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("product_model", 32'(prod), 32'(exp_product(mc, mu)));
        check("iter_sequence", 32'(ilog), 32'(l_iter));
        check("iter_at_done", 32'(iter), 32'd0);
        if (pin) begin
            check("product_literal", 32'(prod), 32'(l_prod));
            check("latency", 32'(lat), 32'(l_lat));
            check("busy_cycles", 32'(busy_n), 32'(l_lat - 1));
            check("arith_ctrl_seq", 32'(alog), 32'(l_arith));
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time budget (%0d vectors, %0d miscompares)", n_vec, n_mis);
        $fatal(1);
    end

    initial begin
        int           n_done, shifts, cyc;
        int           done_cyc [2];
        logic [2*W-1:0] prod;

        #1 reset_n = 1'b0;
        repeat (2) @(negedge clock);
        check("reset_outputs", outs(), 32'h0F00);
        #1 reset_n = 1'b1;
        repeat (3) @(negedge clock);
        check("idle_after_reset", outs(), 32'h0F00);
        @(posedge clock);
        #1;

        run_op(4'b0011, 4'b0110, PIN, 8'h12, 10, 12'hC70, 16'h4321);
        run_op(4'b0011, 4'b1110, PIN, 8'hFA, 10, 12'hC76, 16'h4321);
        run_op(4'b1000, 4'b1000, PIN, 8'h40, 10, 12'hDB1, 16'h4321);
`ifdef BOOTH_SKIP_EN
        run_op(4'b0011, 4'b0000, 1'b1, 8'h00, 6,  12'h000, 16'h4321);
        run_op(4'b0011, 4'b0101, 1'b1, 8'h0F, 10, 12'h208, 16'h4321);
`endif

        // Extra start pulse a few cycles into an operation must be ignored.
        mcand_in = 4'b0010;
        mult_in  = 4'b0011;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1 start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        n_done = 0;
        prod   = '0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clock);
            if (done) begin
                n_done++;
                prod = {a_r[W-1:0], q_r};
            end
        end
        check("single_done_with_busy_start", 32'(n_done), 32'd1);
        check("busy_start_product", 32'(prod), 32'h06);
        @(posedge clock);
        #1;

        // start held high: back-to-back operations with one DONE cycle between.
        mcand_in = 4'b0101;
        mult_in  = 4'b1011;
        start    = 1'b1;
        n_done   = 0;
        cyc      = 0;
        done_cyc[0] = 0;
        done_cyc[1] = 0;
        for (int c = 0; c < 60 && n_done < 2; c++) begin
            @(negedge clock);
            cyc++;
            if (done) begin
                done_cyc[n_done] = cyc;
                n_done++;
                check("held_product_model", 32'({a_r[W-1:0], q_r}), 32'(exp_product(4'b0101, 4'b1011)));
                check("held_product_literal", 32'({a_r[W-1:0], q_r}), 32'hE7);
            end
        end
        #1 start = 1'b0;
        check("held_two_dones", 32'(n_done), 32'd2);
        if (PIN) check("held_done_spacing", 32'(done_cyc[1] - done_cyc[0]), 32'd10);
        repeat (2) @(posedge clock);
        #1;

        // Asynchronous reset during the third SHIFT.
        mcand_in = 4'b0011;
        mult_in  = 4'b0110;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        shifts = 0;
        for (int c = 0; c < 40 && shifts < 3; c++) begin
            @(negedge clock);
            if (q_ctrl == 2'b10) shifts++;
        end
        check("third_shift_reached", 32'(shifts), 32'd3);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", outs(), 32'h0F00);
        @(negedge clock);
        #1 reset_n = 1'b1;
        repeat (4) @(negedge clock);
        check("idle_after_midop_reset", outs(), 32'h0F00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
